// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage program-counter unit.
// FSM encoding and the sequential fetch step size.
package pc_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_state_e;

   localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_unit.sv
// Fetch-stage PC unit: next-PC priority select, boot/run/halt FSM
// and a valid/ready fetch request towards instruction memory.
module pc_unit
   import pc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              IALIGN       = 4
) (
   input  logic            clk_pc,
   input  logic            rst_pc,
   input  logic            stall_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic            trap_i,
   input  logic [XLEN-1:0] trap_vec_i,
   input  logic            halt_i,
   input  logic            resume_i,
   input  logic [XLEN-1:0] resume_pc_i,
   input  logic            fetch_ready_i,
   output logic            fetch_valid_o,
   output logic [XLEN-1:0] program_counter,
   output logic [XLEN-1:0] pc_plus_o,
   output logic            misaligned_o,
   output logic [XLEN-1:0] misaligned_addr_o,
   output logic [1:0]      state_o
);

   localparam int ALIGN_BITS = $clog2(IALIGN);

   pc_state_e       state_q, state_nx;
   logic [XLEN-1:0] pc_q, pc_nx;
   logic            mis_q, mis_nx;
   logic [XLEN-1:0] maddr_q, maddr_nx;
   logic [XLEN-1:0] pc_inc;
   logic [XLEN-1:0] resume_al;
   logic            tgt_misal;

   assign pc_inc    = pc_q + XLEN'(PC_STEP);
   assign tgt_misal = |redirect_pc_i[ALIGN_BITS-1:0];
   assign resume_al = {resume_pc_i[XLEN-1:ALIGN_BITS],
                       {ALIGN_BITS{1'b0}}};

   always_ff @(posedge clk_pc) begin
      if (rst_pc) begin
         state_q <= BOOT;
         pc_q    <= RESET_VECTOR;
         mis_q   <= 1'b0;
         maddr_q <= '0;
      end else begin
         state_q <= state_nx;
         pc_q    <= pc_nx;
         mis_q   <= mis_nx;
         maddr_q <= maddr_nx;
      end
   end

   // Trap and redirect preempt stall/ready: the pending fetch is dropped.
   always_comb begin
      state_nx = state_q;
      pc_nx    = pc_q;
      mis_nx   = 1'b0;
      maddr_nx = maddr_q;
      unique case (state_q)
         BOOT: state_nx = RUN;
         RUN: begin
            if (trap_i) begin
               pc_nx = trap_vec_i;
            end else if (redirect_i && !tgt_misal) begin
               pc_nx = redirect_pc_i;
            end else if (redirect_i) begin
               pc_nx    = trap_vec_i;
               mis_nx   = 1'b1;
               maddr_nx = redirect_pc_i;
            end else if (halt_i) begin
               state_nx = HALT;
            end else if (!stall_i && fetch_ready_i) begin
               pc_nx = pc_inc;
            end
         end
         HALT: begin
            if (resume_i) begin
               pc_nx    = resume_al;
               state_nx = RUN;
            end
         end
         default: state_nx = BOOT;
      endcase
   end

   always_comb begin
      fetch_valid_o = (state_q == RUN);
      state_o       = state_q;
   end

   assign program_counter   = pc_q;
   assign pc_plus_o         = pc_inc;
   assign misaligned_o      = mis_q;
   assign misaligned_addr_o = maddr_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus random
// stimulus against a rule-level reference model.
module tb_pc_unit;

   localparam logic [31:0] RV = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redir = 1'b0;
   logic [31:0] redir_pc = '0;
   logic        trap = 1'b0;
   logic [31:0] trap_vec = '0;
   logic        halt = 1'b0;
   logic        resume = 1'b0;
   logic [31:0] resume_pc = '0;
   logic        ready = 1'b1;
   logic        valid;
   logic [31:0] pc;
   logic [31:0] pc_plus;
   logic        mis;
   logic [31:0] mis_addr;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;

   // reference model: mode 0=boot, 1=run, 2=halt
   int          m_mode;
   logic [31:0] m_pc;
   logic        m_mis;
   logic [31:0] m_maddr;

   pc_unit #(
      .XLEN(32),
      .RESET_VECTOR(RV),
      .IALIGN(4)
   ) dut (
      .clk_pc(clk),
      .rst_pc(rst),
      .stall_i(stall),
      .redirect_i(redir),
      .redirect_pc_i(redir_pc),
      .trap_i(trap),
      .trap_vec_i(trap_vec),
      .halt_i(halt),
      .resume_i(resume),
      .resume_pc_i(resume_pc),
      .fetch_ready_i(ready),
      .fetch_valid_o(valid),
      .program_counter(pc),
      .pc_plus_o(pc_plus),
      .misaligned_o(mis),
      .misaligned_addr_o(mis_addr),
      .state_o(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         m_mode  = 0;
         m_pc    = RV;
         m_mis   = 1'b0;
         m_maddr = '0;
      end else begin
         m_mis = 1'b0;
         case (m_mode)
            0: m_mode = 1;
            1: begin
               if (trap) begin
                  m_pc = trap_vec;
               end else if (redir && (redir_pc % 4 == 0)) begin
                  m_pc = redir_pc;
               end else if (redir) begin
                  m_pc    = trap_vec;
                  m_mis   = 1'b1;
                  m_maddr = redir_pc;
               end else if (halt) begin
                  m_mode = 2;
               end else if (!stall && ready) begin
                  m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
               end
            end
            default: begin
               if (resume) begin
                  m_pc   = resume_pc - (resume_pc % 4);
                  m_mode = 1;
               end
            end
         endcase
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc"}, pc, m_pc);
      check({tag, ".plus"}, pc_plus, m_pc + 32'd4);
      check({tag, ".valid"}, 32'(valid), 32'(m_mode == 1));
      check({tag, ".state"}, 32'(state), 32'(m_mode));
      check({tag, ".mis"}, 32'(mis), 32'(m_mis));
      check({tag, ".maddr"}, mis_addr, m_maddr);
   endtask

   task automatic step(input string tag,
                       input logic r, input logic s,
                       input logic rd, input logic [31:0] rpc,
                       input logic t, input logic [31:0] tv,
                       input logic h, input logic rs,
                       input logic [31:0] rspc, input logic rdy);
      rst = r; stall = s; redir = rd; redir_pc = rpc;
      trap = t; trap_vec = tv; halt = h; resume = rs;
      resume_pc = rspc; ready = rdy;
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag, input logic rdy);
      step(tag, 0, 0, 0, 0, 0, 32'h100, 0, 0, 0, rdy);
   endtask

   task automatic go(input string tag, input logic [31:0] tgt);
      step(tag, 0, 0, 1, tgt, 0, 32'h100, 0, 0, 0, 1);
   endtask

   initial begin
      // reset and boot sequence
      step("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step("rst", 1, 1, 1, 32'h44, 1, 32'h8, 1, 1, 0, 1);
      check("rst_pc", pc, RV);
      check("rst_state", 32'(state), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      idle("boot", 1);
      check("boot_pc0", pc, 32'h1000);
      check("boot_valid", 32'(valid), 32'd1);
      idle("run1", 1);
      check("boot_pc1", pc, 32'h1004);
      idle("run2", 1);
      check("boot_pc2", pc, 32'h1008);

      // fetch_ready low holds the address
      go("to20", 32'h20);
      for (int i = 0; i < 3; i++) begin
         idle("nrdy", 0);
         check("nrdy_pc", pc, 32'h20);
      end
      idle("rdy", 1);
      check("rdy_pc", pc, 32'h24);

      // redirect and trap override stall
      step("stred", 0, 1, 1, 32'h400, 0, 32'h100, 0, 0, 0, 0);
      check("stred_pc", pc, 32'h400);
      step("sttrap", 0, 1, 1, 32'h800, 1, 32'h100, 0, 0, 0, 0);
      check("sttrap_pc", pc, 32'h100);

      // misaligned redirect
      step("misal", 0, 0, 1, 32'h402, 0, 32'h300, 0, 0, 0, 1);
      check("misal_pc", pc, 32'h300);
      check("misal_pulse", 32'(mis), 32'd1);
      check("misal_addr", mis_addr, 32'h402);
      idle("misal2", 1);
      check("misal_end", 32'(mis), 32'd0);
      check("misal_hold", mis_addr, 32'h402);

      // halt, ignored redirect, resume with alignment
      go("to80", 32'h80);
      step("halt", 0, 0, 0, 0, 0, 32'h100, 1, 0, 0, 1);
      check("halt_state", 32'(state), 32'd2);
      check("halt_valid", 32'(valid), 32'd0);
      step("hredir", 0, 0, 1, 32'h600, 1, 32'h100, 1, 0, 0, 1);
      check("hredir_pc", pc, 32'h80);
      step("resume", 0, 0, 0, 0, 0, 32'h100, 0, 1, 32'h203, 1);
      check("resume_pc", pc, 32'h200);
      check("resume_state", 32'(state), 32'd1);

      // wrap-around and reset from HALT
      go("toend", 32'hFFFF_FFFC);
      idle("wrap", 1);
      check("wrap_pc", pc, 32'h0);
      step("halt2", 0, 0, 0, 0, 0, 32'h100, 1, 0, 0, 1);
      step("hrst", 1, 0, 1, 32'h40, 0, 32'h100, 1, 1, 32'h40, 1);
      check("hrst_state", 32'(state), 32'd0);
      check("hrst_pc", pc, RV);

      // random stimulus
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] rpc;
         logic [31:0] tv;
         logic [31:0] rspc;
         rpc  = $urandom & 32'hFFFF_FFF0;
         rpc  = rpc | (($urandom_range(0, 3) == 0) ?
                       32'($urandom_range(1, 3)) : 32'h0);
         tv   = $urandom & 32'hFFFF_FFFC;
         rspc = $urandom;
         step("rnd",
              $urandom_range(0, 99) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 7) == 0,
              rpc,
              $urandom_range(0, 15) == 0,
              tv,
              $urandom_range(0, 15) == 0,
              $urandom_range(0, 3) == 0,
              rspc,
              $urandom_range(0, 3) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised fetch-stage program-counter unit for the pipelined RV32I core. It replaces the bare PC register with next-PC selection, a small control FSM (boot/run/halt) and a valid/ready handshake towards instruction memory. It also handles the hazard-unit stall, EX-stage branch/jump redirects, trap vectoring and misaligned-target detection.

## Interface
- XLEN, 32: PC and address width.
- RESET_VECTOR, 32'h0000_0000: PC value after reset.
- IALIGN, 4: required target alignment in bytes (4 now; 2 reserved for the C extension).
- clk_pc  in  1  clock, all state updates on rising edge.
- rst_pc  in  1  reset, synchronous, active-high.
- stall_i  in  1  hazard-unit hold request.
- redirect_i  in  1  branch/jump taken, resolved in EX.
- redirect_pc_i  in  XLEN  redirect target.
- trap_i  in  1  exception/interrupt taken.
- trap_vec_i  in  XLEN  trap target (mtvec).
- halt_i  in  1  debug halt request.
- resume_i  in  1  leave HALT.
- resume_pc_i  in  XLEN  PC to resume at.
- fetch_ready_i  in  1  imem accepts the current address.
- fetch_valid_o  out  1  program_counter is a valid fetch request.
- program_counter  out  XLEN  current fetch address (registered).
- pc_plus_o  out  XLEN  program_counter + 4, combinational.
- misaligned_o  out  1  one-cycle pulse: misaligned redirect trapped.
- misaligned_addr_o  out  XLEN  offending target, held until next misalignment or reset.
- state_o  out  2  current FSM state.

## Operation
- States: BOOT, RUN, HALT.
- BOOT: fetch_valid_o=0, PC holds RESET_VECTOR; unconditionally -> RUN next cycle. All inputs ignored.
- RUN: fetch_valid_o=1. Next-PC priority, highest first:
  - trap_i: PC <= trap_vec_i.
  - redirect_i, target aligned (target mod IALIGN = 0): PC <= redirect_pc_i.
  - redirect_i, target misaligned: PC <= trap_vec_i; misaligned_o=1 next cycle; misaligned_addr_o <= redirect_pc_i.
  - halt_i: -> HALT, PC holds.
  - stall_i, or fetch_ready_i=0: PC holds.
  - otherwise: PC <= PC + 4.
- Trap and redirect override stall and fetch_ready_i; the pending fetch is abandoned (imem sees a new address next cycle).
- HALT: fetch_valid_o=0, PC holds; trap_i, redirect_i, stall_i and halt_i are ignored. resume_i: PC <= resume_pc_i with bits [log2(IALIGN)-1:0] forced to 0, -> RUN.
- Arithmetic: increment is modulo 2^XLEN; PC 32'hFFFF_FFFC + 4 = 0, no flag.
- trap_vec_i is used unchecked; software guarantees its alignment.

## Timing
- Reset values: program_counter=RESET_VECTOR, state_o=BOOT, fetch_valid_o=0, misaligned_o=0, misaligned_addr_o=0.
- rst_pc wins over every other input in any state, including mid-redirect and mid-HALT.
- First valid fetch: the second rising edge after rst_pc deasserts, at RESET_VECTOR.
- Redirect/trap asserted in cycle n -> program_counter = target in cycle n+1. Single-cycle latency, no bubbles inserted by this block.
- Handshake: a fetch completes on a cycle with fetch_valid_o & fetch_ready_i; the address is stable while the fetch is valid and not ready, unless trap or redirect.
- fetch_valid_o and state_o are Moore outputs (from state only). misaligned_o is registered, high for exactly one cycle.

## Structure
- Package pc_pkg: pc_state_e enum (BOOT=2'd0, RUN=2'd1, HALT=2'd2) and PC_STEP=4.
- Single module, no sub-module. Next-PC selection is one combinational priority block feeding the PC and state registers.

## Test plan
- Reset then idle, RESET_VECTOR=32'h0000_1000, fetch_ready_i=1 -> BOOT for 1 cycle, then PCs 0x1000, 0x1004, 0x1008; fetch_valid_o low in BOOT only.
- fetch_ready_i=0 for 3 cycles at PC 0x20 -> PC stays 0x20 with valid high; 0x24 the cycle after ready returns.
- stall_i=1 and redirect_i=1 to 0x400 in the same cycle -> PC=0x400 next cycle; trap_i added to the same cycle with trap_vec_i=0x100 -> PC=0x100.
- redirect_pc_i=0x402 -> PC=trap_vec_i, misaligned_o pulses one cycle, misaligned_addr_o=0x402.
- halt_i at PC 0x80 -> HALT, valid 0, redirect ignored; resume_i with resume_pc_i=0x203 -> PC=0x200 in RUN.
- PC 32'hFFFF_FFFC, no stall -> PC 0; rst_pc asserted while in HALT -> BOOT, PC=RESET_VECTOR.
